// File: rtl/jtframe_dwnld_ctrl.sv
// ROM download controller: routes ioctl bytes to a small SDRAM write queue or
// straight to PROM, and sequences the game/loop reset around the download.
module jtframe_dwnld_ctrl #(
    parameter logic [21:0] PROM_START = 22'h1F_FC00,
    parameter int          FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic        prom_we,
    output logic [9:0]  prom_addr,
    output logic [7:0]  prom_din,
    output logic        loop_rst,
    output logic        dwnld_done,
    output logic        overflow
);
    // state | meaning
    // IDLE  | waiting for a download to start
    // LOAD  | bytes arriving, game held in reset
    // DRAIN | loader finished, queued SDRAM writes still retiring
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam int                 DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = (FIFO_AW)'(1);

    state_t state, state_nxt;

    logic [21:0]        fifo_addr [DEPTH];
    logic [7:0]         fifo_data [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               dl_last;

    logic strobe, is_prom, push_req, prom_req;
    logic empty, full, pop, push, drop, dl_rise;
    logic [21:0] head_addr;

    assign strobe   = downloading & ioctl_wr;
    assign is_prom  = ioctl_addr >= PROM_START;
    assign push_req = strobe & ~is_prom;
    assign prom_req = strobe & is_prom;
    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);
    assign pop      = prog_ack & ~empty;
    // a full queue can still take a byte when the head retires in the same cycle
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign dl_rise  = downloading & ~dl_last;
    assign head_addr = fifo_addr[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr;
            fifo_data[wr_ptr] <= ioctl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dl_last   <= 1'b0;
            overflow  <= 1'b0;
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_din  <= '0;
        end else begin
            state   <= state_nxt;
            dl_last <= downloading;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // a byte lost on the very cycle a new download starts still counts
            if (dl_rise)   overflow <= drop;
            else if (drop) overflow <= 1'b1;
            prom_we <= prom_req;
            if (prom_req) begin
                prom_addr <= ioctl_addr[9:0] - PROM_START[9:0];
                prom_din  <= ioctl_data;
            end
        end
    end

    always_comb begin
        prog_we   = ~empty;
        prog_addr = '0;
        prog_data = '0;
        prog_mask = 2'b11;
        if (!empty) begin
            prog_addr = {1'b0, head_addr[21:1]};
            prog_data = fifo_data[rd_ptr];
            prog_mask = head_addr[0] ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        state_nxt  = state;
        loop_rst   = 1'b0;
        dwnld_done = 1'b0;
        case (state)
            IDLE: if (downloading) state_nxt = LOAD;
            LOAD: begin
                loop_rst = 1'b1;
                if (!downloading) state_nxt = empty ? DONE : DRAIN;
            end
            DRAIN: begin
                loop_rst = 1'b1;
                if (downloading)  state_nxt = LOAD;
                else if (empty)   state_nxt = DONE;
            end
            DONE: begin
                dwnld_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_jtframe_dwnld_ctrl.sv
// Bench for jtframe_dwnld_ctrl: vector table for single bytes plus
// hand sequences for overflow, full+ack, drain/done and mid-load reset.
module tb_jtframe_dwnld_ctrl;
    localparam logic [21:0] PS = 22'h1F_FC00;

    logic        clk = 1'b0;
    logic        rst_n, downloading, ioctl_wr, prog_ack;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data, prom_din;
    logic [1:0]  prog_mask;
    logic        prog_we, prom_we, loop_rst, dwnld_done, overflow;
    logic [9:0]  prom_addr;

    jtframe_dwnld_ctrl #(.PROM_START(PS), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack),
        .prom_we(prom_we), .prom_addr(prom_addr), .prom_din(prom_din),
        .loop_rst(loop_rst), .dwnld_done(dwnld_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } wr_t;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic        prom;
        logic [21:0] exp_paddr;
        logic [1:0]  exp_mask;
        logic [9:0]  exp_prom_addr;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_ovf = 1'b0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag);
        check({tag, "_we"}, 32'(prog_we), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check({tag, "_addr"}, 32'(prog_addr), 32'({1'b0, sb[0].addr[21:1]}));
            check({tag, "_data"}, 32'(prog_data), 32'(sb[0].data));
            check({tag, "_mask"}, 32'(prog_mask), 32'(sb[0].mask));
        end
    endtask

    task automatic ack_one(input string tag);
        check_head(tag);
        prog_ack = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        step;
        prog_ack = 1'b0;
    endtask

    task automatic strobe(input logic [21:0] a, input logic [7:0] d, input logic ack);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        prog_ack   = ack;
        if (ack && sb.size() != 0) begin
            check_head("ack_wr");
            void'(sb.pop_front());
        end
        if (downloading && a < PS) begin
            if (sb.size() < 4) sb.push_back('{a, d, a[0] ? 2'b01 : 2'b10});
            else exp_ovf = 1'b1;
        end
        step;
        ioctl_wr = 1'b0;
        prog_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_prog_we"},    32'(prog_we),    32'd0);
        check({tag, "_prog_mask"},  32'(prog_mask),  32'd3);
        check({tag, "_prog_addr"},  32'(prog_addr),  32'd0);
        check({tag, "_prog_data"},  32'(prog_data),  32'd0);
        check({tag, "_prom_we"},    32'(prom_we),    32'd0);
        check({tag, "_prom_addr"},  32'(prom_addr),  32'd0);
        check({tag, "_prom_din"},   32'(prom_din),   32'd0);
        check({tag, "_loop_rst"},   32'(loop_rst),   32'd0);
        check({tag, "_dwnld_done"}, 32'(dwnld_done), 32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{22'h000005, 8'hA5, 1'b0, 22'h000002, 2'b01, 10'h000};
        vecs[1] = '{22'h000000, 8'h11, 1'b0, 22'h000000, 2'b10, 10'h000};
        vecs[2] = '{22'h3FFFFF, 8'h5A, 1'b1, 22'h000000, 2'b11, 10'h3FF};
        vecs[3] = '{22'h1FFBFF, 8'h77, 1'b0, 22'h0FFDFF, 2'b01, 10'h000};
        vecs[4] = '{22'h1FFC00, 8'h42, 1'b1, 22'h000000, 2'b11, 10'h000};
        vecs[5] = '{22'h1FFC03, 8'h3C, 1'b1, 22'h000000, 2'b11, 10'h003};
        vecs[6] = '{22'h12345A, 8'hC3, 1'b0, 22'h091A2D, 2'b10, 10'h000};

        rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        step; step;
        check_reset_vals("rst");
        rst_n = 1'b1;
        strobe(22'h000010, 8'hEE, 1'b0);
        check("idle_ignore_we", 32'(prog_we), 32'd0);
        check("idle_loop_rst", 32'(loop_rst), 32'd0);
        downloading = 1'b1;
        step;
        check("load_loop_rst", 32'(loop_rst), 32'd1);

        for (int i = 0; i < 7; i++) begin
            strobe(vecs[i].addr, vecs[i].data, 1'b0);
            if (vecs[i].prom) begin
                check("prom_we", 32'(prom_we), 32'd1);
                check("prom_addr", 32'(prom_addr), 32'(vecs[i].exp_prom_addr));
                check("prom_din", 32'(prom_din), 32'(vecs[i].data));
                check("prom_prog_we", 32'(prog_we), 32'd0);
                step;
                check("prom_we_pulse", 32'(prom_we), 32'd0);
            end else begin
                check("vec_we", 32'(prog_we), 32'd1);
                check("vec_addr", 32'(prog_addr), 32'(vecs[i].exp_paddr));
                check("vec_mask", 32'(prog_mask), 32'(vecs[i].exp_mask));
                check("vec_data", 32'(prog_data), 32'(vecs[i].data));
                check("vec_prom_we", 32'(prom_we), 32'd0);
                step;
                check_head("vec_hold");
                ack_one("vec");
                check("vec_we_drop", 32'(prog_we), 32'd0);
            end
        end

        check("pre_burst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) strobe(22'(i), 8'(8'h10 + i), 1'b0);
        check("burst_ovf", 32'(overflow), 32'(exp_ovf));
        for (int i = 0; i < 4; i++) begin
            ack_one("burst");
            step;
        end
        check("burst_empty", 32'(prog_we), 32'd0);
        check("burst_ovf_sticky", 32'(overflow), 32'd1);

        downloading = 1'b0;
        step;
        check("direct_done", 32'(dwnld_done), 32'd1);
        check("direct_done_lr", 32'(loop_rst), 32'd0);
        step;
        check("done_pulse", 32'(dwnld_done), 32'd0);
        check("ovf_hold_idle", 32'(overflow), 32'd1);
        downloading = 1'b1;
        exp_ovf = 1'b0;
        step;
        check("ovf_clear", 32'(overflow), 32'(exp_ovf));

        for (int i = 0; i < 4; i++) strobe(22'(40 + i), 8'(8'h80 + i), 1'b0);
        strobe(22'd44, 8'h84, 1'b1);
        check("full_ack_ovf", 32'(overflow), 32'(exp_ovf));
        for (int i = 0; i < 4; i++) ack_one("full");
        check("full_drained", 32'(prog_we), 32'd0);

        strobe(22'd20, 8'hD0, 1'b0);
        strobe(22'd21, 8'hD1, 1'b0);
        downloading = 1'b0;
        ioctl_addr = 22'd30; ioctl_data = 8'hBB; ioctl_wr = 1'b1;
        step;
        ioctl_wr = 1'b0;
        check("drain_lr0", 32'(loop_rst), 32'd1);
        check("drain_done0", 32'(dwnld_done), 32'd0);
        ack_one("drain");
        check("drain_lr1", 32'(loop_rst), 32'd1);
        ack_one("drain");
        check("drain_lr2", 32'(loop_rst), 32'd1);
        check("drain_done2", 32'(dwnld_done), 32'd0);
        check("drain_we2", 32'(prog_we), 32'd0);
        step;
        check("drain_done", 32'(dwnld_done), 32'd1);
        check("drain_lr_off", 32'(loop_rst), 32'd0);
        step;
        check("drain_done_end", 32'(dwnld_done), 32'd0);
        check("drain_ignored_wr", 32'(prog_we), 32'd0);

        downloading = 1'b1;
        step;
        for (int i = 0; i < 3; i++) strobe(22'(50 + i), 8'(8'h60 + i), 1'b0);
        check("mid_we", 32'(prog_we), 32'd1);
        rst_n = 1'b0;
        step;
        check_reset_vals("mid_rst");
        rst_n = 1'b1;
        sb.delete();
        exp_ovf = 1'b0;
        step;
        check("restart_lr", 32'(loop_rst), 32'd1);
        check("restart_we", 32'(prog_we), 32'd0);
        step;
        check("restart_we2", 32'(prog_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtframe_dwnld_ctrl.md
JTFRAME_DWNLD_CTRL -- requirements
Module: jtframe_dwnld_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PROM_START, 22'h1F_FC00: first ioctl byte address routed to PROM; lower addresses go to SDRAM.
- FIFO_AW, 2: log2 of SDRAM write-queue depth (depth 4).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock; the single clock of the block.
- rst_n  in  1  reset, synchronous, active-low.
- downloading  in  1  ROM download in progress, from the SPI loader.
- ioctl_addr  in  22  byte address of the current download byte.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  one-cycle byte strobe.
- prog_addr  out  22  SDRAM word address.
- prog_data  out  8  byte to write.
- prog_mask  out  2  active-low byte-lane mask; bit0 is the low byte.
- prog_we  out  1  SDRAM write request, held until acknowledged.
- prog_ack  in  1  one-cycle SDRAM acceptance.
- prom_we  out  1  one-cycle PROM write strobe.
- prom_addr  out  10  PROM byte address.
- prom_din  out  8  PROM data.
- loop_rst  out  1  holds the SDRAM read loop and game in reset while loading.
- dwnld_done  out  1  one-cycle pulse when the download has fully retired.
- overflow  out  1  sticky flag: a byte was dropped.

Function
REQ-003 ioctl_wr SHALL be ignored while downloading=0.

REQ-004 A strobe with ioctl_addr < PROM_START SHALL push {ioctl_addr, ioctl_data} into a FIFO of 2^FIFO_AW entries.

REQ-005 A strobe with ioctl_addr >= PROM_START SHALL bypass the FIFO:
- prom_we=1 for exactly one cycle, on the cycle after the strobe.
- prom_addr=(ioctl_addr-PROM_START)[9:0].
- prom_din=ioctl_data.

REQ-006 While the FIFO is non-empty, prog_we SHALL be 1 and present the head entry:
- prog_addr={1'b0, addr[21:1]}.
- prog_data=data.
- prog_mask=2'b10 when addr[0]=0, 2'b01 when addr[0]=1.

REQ-007 Latency SHALL be: a strobe at cycle N into an empty FIFO gives prog_we=1 at cycle N+1.

REQ-008 prog_ack with prog_we=1 SHALL pop the head; prog_we SHALL drop in the next cycle if the FIFO is then empty. prog_ack with prog_we=0 SHALL be ignored.

REQ-009 prog_addr, prog_data and prog_mask SHALL remain stable while prog_we=1 and prog_ack=0.

REQ-010 A push and a pop in the same cycle SHALL both take effect; the occupancy count is unchanged.

REQ-011 Full-FIFO rules:
- A push while full with prog_ack=1 SHALL be accepted.
- A push while full with prog_ack=0 SHALL drop the byte and set overflow=1.

REQ-012 overflow SHALL clear only on reset or on a rising edge of downloading.

REQ-013 The control FSM SHALL have states IDLE, LOAD, DRAIN, DONE with these transitions:
- IDLE->LOAD on downloading=1.
- LOAD->DRAIN on downloading=0.
- DRAIN->DONE when the FIFO is empty.
- DRAIN->LOAD if downloading returns to 1; no dwnld_done is issued.
- DONE->IDLE unconditionally after one cycle.
- LOAD->DONE directly if downloading=0 and the FIFO is already empty.

REQ-014 loop_rst SHALL be 1 in LOAD and DRAIN and 0 in IDLE and DONE.

REQ-015 dwnld_done SHALL be 1 only in DONE.

REQ-016 Bytes written while in DRAIN SHALL be impossible, because of REQ-003.

REQ-017 Occupancy SHALL be held in an FIFO_AW+1 bit counter; read and write pointers SHALL wrap modulo 2^FIFO_AW.

Reset
REQ-018 With rst_n=0 sampled on a rising clk edge, the block SHALL enter:
- FSM=IDLE, FIFO empty, pointers 0.
- prog_we=0, prog_mask=2'b11, prog_addr=0, prog_data=0.
- prom_we=0, prom_addr=0, prom_din=0.
- loop_rst=0, dwnld_done=0, overflow=0.

REQ-019 Reset asserted mid-download SHALL discard all queued entries, with no prog_we after reset.

REQ-020 After reset deasserts, the FSM SHALL wait in IDLE for downloading=1.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Single byte: downloading=1, strobe addr=22'h000005, data=8'hA5 -> next cycle prog_we=1, prog_addr=22'h000002, prog_data=8'hA5, prog_mask=2'b01; ack -> prog_we=0.
- Burst with prog_ack tied 0: 5 strobes at addr 0..4 -> entries 0..3 queued, byte 4 dropped, overflow=1; then ack x4 -> four writes in order, addr[0] alternating masks 2'b10/2'b01.
- PROM path: strobe addr=PROM_START+3, data=8'h3C -> one-cycle prom_we, prom_addr=3, prom_din=8'h3C; FIFO and prog_we unchanged.
- Drain/done: 2 entries queued, downloading falls -> loop_rst stays 1 until the second ack, then dwnld_done pulses 1 cycle and loop_rst=0; an ioctl_wr after the fall is ignored.
- Full plus simultaneous ack: FIFO full, strobe coincides with prog_ack -> byte accepted, occupancy remains 4, overflow stays 0.
- Reset mid-load: 3 entries queued, rst_n=0 for one cycle -> all outputs at REQ-018 values; no stale prog_we when downloading restarts.
